// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the single-clock FIFO.
// Pointer width, read-mode encodings and parameter sanity checks.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Address bits plus one wrap bit, so SIZE entries are all usable.
    function automatic int ptr_width(input int size);
        return $clog2(size) + 1;
    endfunction

    function automatic bit size_ok(input int size);
        return (size >= 4) && ((size & (size - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(
        input int size,
        input int afull,
        input int aempty
    );
        return (afull <= size) && (aempty < size);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake and status bundle of sync_fifo.
// master drives requests and data; slave is the FIFO itself.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SIZE  = 1024
);

    localparam int CW = ptr_width(SIZE);

    logic             wren;
    logic [WIDTH-1:0] wrdata;
    logic             full;
    logic             almost_full;
    logic             rden;
    logic [WIDTH-1:0] rddata;
    logic             rdvalid;
    logic             empty;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wren, wrdata, rden,
        input  full, almost_full, rddata, rdvalid,
        input  empty, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  wren, wrdata, rden,
        output full, almost_full, rddata, rdvalid,
        output empty, almost_empty, count,
        output overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_fwft_stage.sv
// fifo_fwft_stage: two-deep prefetch (RAM read register + output
// register) that presents the head word without a read request.
module fifo_fwft_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             avail,
    input  logic [WIDTH-1:0] ram_q,
    input  logic             rden,
    output logic             fetch,
    output logic [WIDTH-1:0] rddata,
    output logic             rdvalid
);

    logic q_valid;
    logic pop;
    logic load;

    assign pop   = rden && rdvalid;
    assign load  = q_valid && (!rdvalid || pop);
    assign fetch = avail && (!q_valid || load);

    // RAM read register occupancy; refilled while it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
        end else begin
            q_valid <= fetch || (q_valid && !load);
        end
    end

    // Output register: loads when empty or when its word is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdvalid <= 1'b0;
            rddata  <= '0;
        end else begin
            rdvalid <= load || (rdvalid && !pop);
            if (load) begin
                rddata <= ram_q;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_ram.sv
// ram: simple dual-port storage, one write port and one registered
// read port; both clocks may be tied together.
module ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1024,
    parameter int ABITS = $clog2(DEPTH)
) (
    input  logic             wrclk,
    input  logic             wren,
    input  logic [ABITS-1:0] wraddr,
    input  logic [WIDTH-1:0] wrdata,
    input  logic             rdclk,
    input  logic             rden,
    input  logic [ABITS-1:0] rdaddr,
    output logic [WIDTH-1:0] rddata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge wrclk) begin
        if (wren) begin
            mem[wraddr] <= wrdata;
        end
    end

    // Registered read port; holds its value when not reading.
    always_ff @(posedge rdclk) begin
        if (rden) begin
            rddata <= mem[rdaddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, standard or first-word-fall-through.
// Define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow + checks.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int SIZE          = 1024,
    parameter int FWFT          = FIFO_MODE_STD,
    parameter int AFULL_THRESH  = SIZE - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input logic        clk,
    input logic        rst_n,
    sync_fifo_if.slave bus
);

    localparam int ABITS = $clog2(SIZE);
    localparam int PW    = ptr_width(SIZE);

    if (!size_ok(SIZE)) begin : g_bad_size
        $error("sync_fifo: SIZE must be a power of two >= 4");
    end

    if (!thresh_ok(SIZE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thr
        $error("sync_fifo: almost-full/empty threshold out of range");
    end

    logic [PW-1:0]    wrptr;
    logic [PW-1:0]    rdptr;
    logic [PW-1:0]    wrptr_n;
    logic [PW-1:0]    rdptr_n;
    logic [PW-1:0]    count_q;
    logic [PW-1:0]    count_n;
    logic             full_q;
    logic             full_n;
    logic             afull_q;
    logic             aempty_q;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_rden;
    logic             empty;
    logic [WIDTH-1:0] ram_q;

    assign wr_acc  = bus.wren && !full_q;
    assign rd_acc  = bus.rden && !empty;
    assign wrptr_n = wrptr + PW'(wr_acc);
    assign rdptr_n = rdptr + PW'(ram_rden);

    // Occupancy after this edge; a read and write together cancel.
    always_comb begin
        count_n = count_q;
        if (wr_acc && !rd_acc) begin
            count_n = count_q + PW'(1);
        end else if (!wr_acc && rd_acc) begin
            count_n = count_q - PW'(1);
        end
    end

    // In FWFT mode words also sit in the prefetch stage, so the count
    // decides fullness; otherwise the pointers alone do.
    assign full_n = (FWFT == FIFO_MODE_FWFT)
        ? (count_n == PW'(SIZE))
        : ((wrptr_n[ABITS] != rdptr_n[ABITS]) &&
           (wrptr_n[ABITS-1:0] == rdptr_n[ABITS-1:0]));

    // Pointers, count and status flags, all from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrptr    <= '0;
            rdptr    <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wrptr    <= wrptr_n;
            rdptr    <= rdptr_n;
            count_q  <= count_n;
            full_q   <= full_n;
            afull_q  <= count_n >= PW'(AFULL_THRESH);
            aempty_q <= count_n <= PW'(AEMPTY_THRESH);
        end
    end

    ram #(
        .WIDTH (WIDTH),
        .DEPTH (SIZE)
    ) u_ram (
        .wrclk  (clk),
        .wren   (wr_acc),
        .wraddr (wrptr[ABITS-1:0]),
        .wrdata (bus.wrdata),
        .rdclk  (clk),
        .rden   (ram_rden),
        .rdaddr (rdptr[ABITS-1:0]),
        .rddata (ram_q)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        logic fetch;

        fifo_fwft_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .avail   (wrptr != rdptr),
            .ram_q   (ram_q),
            .rden    (bus.rden),
            .fetch   (fetch),
            .rddata  (bus.rddata),
            .rdvalid (bus.rdvalid)
        );

        assign ram_rden = fetch;
        assign empty    = !bus.rdvalid;
    end else begin : g_std
        logic             rd_pipe;
        logic             valid_q;
        logic             empty_q;
        logic [WIDTH-1:0] data_q;

        // RAM read, then output register; data holds between reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_pipe <= 1'b0;
                valid_q <= 1'b0;
                empty_q <= 1'b1;
                data_q  <= '0;
            end else begin
                rd_pipe <= rd_acc;
                valid_q <= rd_pipe;
                empty_q <= count_n == '0;
                if (rd_pipe) begin
                    data_q <= ram_q;
                end
            end
        end

        assign ram_rden    = rd_acc;
        assign empty       = empty_q;
        assign bus.rddata  = data_q;
        assign bus.rdvalid = valid_q;
    end

    assign bus.full         = full_q;
    assign bus.almost_full  = afull_q;
    assign bus.empty        = empty;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          ovf_q;
    logic          unf_q;
    logic [PW-1:0] held;

    // Remember any dropped write or ignored read until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.wren && full_q) begin
                ovf_q <= 1'b1;
            end
            if (bus.rden && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

    if (FWFT == FIFO_MODE_FWFT) begin : g_held_fwft
        assign held = PW'(g_fwft.u_stage.q_valid) + PW'(bus.rdvalid);
    end else begin : g_held_std
        assign held = '0;
    end

    a_count_max : assert property (
        @(posedge clk) disable iff (!rst_n)
        count_q <= PW'(SIZE)
    );

    a_full_empty : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(full_q && empty)
    );

    a_count_ptr : assert property (
        @(posedge clk) disable iff (!rst_n)
        count_q == (wrptr - rdptr) + held
    );
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of a standard and an FWFT sync_fifo,
// both SIZE=8 with almost-full 6 and almost-empty 2.
module tb_sync_fifo;

    localparam int W  = 8;
    localparam int S  = 8;
    localparam int CW = $clog2(S) + 1;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    sync_fifo_if #(.WIDTH(W), .SIZE(S)) ia ();
    sync_fifo_if #(.WIDTH(W), .SIZE(S)) ib ();

    sync_fifo #(
        .WIDTH(W), .SIZE(S), .FWFT(0),
        .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );

    sync_fifo #(
        .WIDTH(W), .SIZE(S), .FWFT(1),
        .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic c1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cd(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cc(input string tag, input logic [CW-1:0] obs,
                      input logic [CW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ia.wren = 1'b0; ia.wrdata = '0; ia.rden = 1'b0;
        ib.wren = 1'b0; ib.wrdata = '0; ib.rden = 1'b0;
        step();
        step();

        // power-on reset values
        c1("a_full_rst", ia.full, 1'b0);
        c1("a_afull_rst", ia.almost_full, 1'b0);
        c1("a_empty_rst", ia.empty, 1'b1);
        c1("a_aempty_rst", ia.almost_empty, 1'b1);
        c1("a_rdvalid_rst", ia.rdvalid, 1'b0);
        cd("a_rddata_rst", ia.rddata, 8'h00);
        cc("a_count_rst", ia.count, 4'd0);
        c1("a_ovf_rst", ia.overflow, 1'b0);
        c1("a_unf_rst", ia.underflow, 1'b0);
        c1("b_empty_rst", ib.empty, 1'b1);
        c1("b_rdvalid_rst", ib.rdvalid, 1'b0);
        cd("b_rddata_rst", ib.rddata, 8'h00);
        cc("b_count_rst", ib.count, 4'd0);
        rst_n = 1'b1;

        // three words stored, then asynchronous reset mid-cycle
        ia.wren = 1'b1; ib.wren = 1'b1;
        ia.wrdata = 8'h11; ib.wrdata = 8'h11; step();
        ia.wrdata = 8'h22; ib.wrdata = 8'h22; step();
        ia.wrdata = 8'h33; ib.wrdata = 8'h33; step();
        ia.wren = 1'b0; ib.wren = 1'b0;
        cc("a_count3", ia.count, 4'd3);
        cc("b_count3", ib.count, 4'd3);
        c1("b_rdvalid3", ib.rdvalid, 1'b1);
        cd("b_head3", ib.rddata, 8'h11);
        #3;
        rst_n = 1'b0;
        #1;
        cc("a_count_arst", ia.count, 4'd0);
        c1("a_empty_arst", ia.empty, 1'b1);
        c1("a_aempty_arst", ia.almost_empty, 1'b1);
        c1("b_empty_arst", ib.empty, 1'b1);
        c1("b_rdvalid_arst", ib.rdvalid, 1'b0);
        cd("b_rddata_arst", ib.rddata, 8'h00);
        cc("b_count_arst", ib.count, 4'd0);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        c1("a_empty_post", ia.empty, 1'b1);
        c1("a_rdvalid_post", ia.rdvalid, 1'b0);
        c1("b_empty_post", ib.empty, 1'b1);
        c1("b_rdvalid_post", ib.rdvalid, 1'b0);
        cc("b_count_post", ib.count, 4'd0);

        // FWFT: single write becomes visible two edges later
        ib.wren = 1'b1; ib.wrdata = 8'hA5; step();
        ib.wren = 1'b0;
        cc("b_count1", ib.count, 4'd1);
        c1("b_empty_e0", ib.empty, 1'b1);
        step();
        c1("b_empty_e1", ib.empty, 1'b1);
        step();
        c1("b_empty_e2", ib.empty, 1'b0);
        c1("b_rdvalid_e2", ib.rdvalid, 1'b1);
        cd("b_rddata_e2", ib.rddata, 8'hA5);

        // FWFT: four stored words pop on four consecutive cycles
        ib.wren = 1'b1;
        ib.wrdata = 8'hB0; step();
        ib.wrdata = 8'hB1; step();
        ib.wrdata = 8'hB2; step();
        ib.wren = 1'b0;
        step(); step();
        cc("b_count4", ib.count, 4'd4);
        ib.rden = 1'b1;
        cd("b_pop0", ib.rddata, 8'hA5);
        step();
        cd("b_pop1", ib.rddata, 8'hB0);
        c1("b_pop1_v", ib.rdvalid, 1'b1);
        step();
        cd("b_pop2", ib.rddata, 8'hB1);
        c1("b_pop2_v", ib.rdvalid, 1'b1);
        step();
        cd("b_pop3", ib.rddata, 8'hB2);
        c1("b_pop3_v", ib.rdvalid, 1'b1);
        step();
        c1("b_empty_drained", ib.empty, 1'b1);
        cc("b_count_drained", ib.count, 4'd0);
        step();
        ib.rden = 1'b0;
        cc("b_count_rd_empty", ib.count, 4'd0);
        c1("b_unf", ib.underflow, ERR);

        // standard: fill 0..7 with threshold and full tracking
        for (int i = 0; i < 8; i++) begin
            ia.wren = 1'b1;
            ia.wrdata = 8'(i);
            step();
            cc("a_fill_count", ia.count, 4'(i + 1));
            c1("a_fill_full", ia.full, i == 7);
            c1("a_fill_afull", ia.almost_full, i >= 5);
            c1("a_fill_aempty", ia.almost_empty, i <= 1);
            c1("a_fill_empty", ia.empty, 1'b0);
        end
        ia.wrdata = 8'hEE; step();
        cc("a_count_drop", ia.count, 4'd8);
        c1("a_full_drop", ia.full, 1'b1);
        c1("a_ovf", ia.overflow, ERR);

        // read+write at full: write dropped, then drain in order
        ia.rden = 1'b1; ia.wrdata = 8'h99; step();
        ia.wren = 1'b0;
        cc("a_count_rw_full", ia.count, 4'd7);
        c1("a_full_rw", ia.full, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step();
            cd("a_drain_data", ia.rddata, 8'(k));
            c1("a_drain_valid", ia.rdvalid, 1'b1);
            cc("a_drain_count", ia.count, 4'(6 - k));
        end
        c1("a_empty_drained", ia.empty, 1'b1);
        ia.rden = 1'b0;
        step();
        cd("a_last_data", ia.rddata, 8'h07);
        c1("a_last_valid", ia.rdvalid, 1'b1);
        step();
        c1("a_idle_valid", ia.rdvalid, 1'b0);
        cd("a_idle_hold", ia.rddata, 8'h07);

        // read+write at empty: read ignored
        ia.rden = 1'b1; ia.wren = 1'b1; ia.wrdata = 8'h40; step();
        ia.rden = 1'b0; ia.wren = 1'b0;
        cc("a_count_rw_empty", ia.count, 4'd1);
        c1("a_empty_rw", ia.empty, 1'b0);
        c1("a_unf", ia.underflow, ERR);
        step();
        c1("a_rw_empty_valid", ia.rdvalid, 1'b0);

        // read+write at count 4 keeps count and order
        ia.wren = 1'b1;
        ia.wrdata = 8'h41; step();
        ia.wrdata = 8'h42; step();
        ia.wrdata = 8'h43; step();
        cc("a_count4", ia.count, 4'd4);
        ia.rden = 1'b1;
        for (int j = 0; j < 4; j++) begin
            ia.wrdata = 8'(32'h44 + j);
            step();
            cc("a_rw4_count", ia.count, 4'd4);
            if (j > 0) cd("a_rw4_data", ia.rddata, 8'(32'h40 + j - 1));
        end
        ia.rden = 1'b0; ia.wrdata = 8'h48; step();
        cd("a_rw4_last", ia.rddata, 8'h43);
        cc("a_count5", ia.count, 4'd5);

        // wrap-around: 3*SIZE transfers at constant count 5
        ia.rden = 1'b1;
        for (int j = 0; j < 24; j++) begin
            ia.wrdata = 8'(32'h49 + j);
            step();
            cc("a_wrap_count", ia.count, 4'd5);
            c1("a_wrap_full", ia.full, 1'b0);
            c1("a_wrap_empty", ia.empty, 1'b0);
            if (j > 0) cd("a_wrap_data", ia.rddata, 8'(32'h44 + j - 1));
        end
        ia.wren = 1'b0; ia.rden = 1'b0; step();
        cd("a_wrap_last", ia.rddata, 8'h5B);
        ia.rden = 1'b1;
        step(); step(); step(); step(); step();
        ia.rden = 1'b0;
        step();
        cd("a_final_data", ia.rddata, 8'h60);
        cc("a_final_count", ia.count, 4'd0);
        c1("a_final_empty", ia.empty, 1'b1);

        // error flags stay set until reset
        c1("a_ovf_sticky", ia.overflow, ERR);
        c1("a_unf_sticky", ia.underflow, ERR);
        #3;
        rst_n = 1'b0;
        #1;
        c1("a_ovf_clr", ia.overflow, 1'b0);
        c1("a_unf_clr", ia.underflow, 1'b0);
        c1("b_unf_clr", ib.underflow, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
